udp_cmac_rx_pkt_checker: RTL

- Receive-end checker for the CMAC loopback performance test.
- Consumes the 512-bit AXI-Stream of test packets arriving from the receiving CMAC and checks each packet's sequence number, length, payload pattern and tkeep shape.
- Counts good and errored packets, accepted beats and measurement cycles, and exports all counters as ILA/debug outputs.
- Sits in the xdma_axi_aclk domain, between the receive CMAC wrapper's AXIS output and the performance ILA.

---
 rtl/udp_cmac_rx_pkt_checker_pkg.sv | 34 +++
 rtl/udp_beat_pattern_check.sv | 49 ++++
 rtl/udp_cmac_rx_pkt_checker.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/udp_cmac_rx_pkt_checker_pkg.sv
// Shared definitions for the CMAC loopback receive checker: header layout,
// error flag positions, packet size limits and the AXIS beat record.
package udp_cmac_rx_pkt_checker_pkg;

   localparam int unsigned SEQ_LSB   = 0;
   localparam int unsigned LEN_LSB   = 32;
   localparam int unsigned HDR_BYTES = 8;

   localparam int unsigned ERR_SEQ     = 0;
   localparam int unsigned ERR_LEN     = 1;
   localparam int unsigned ERR_PAYLOAD = 2;
   localparam int unsigned ERR_KEEP    = 3;
   localparam int unsigned ERR_USER    = 4;
   localparam int unsigned ERR_W       = 5;

   localparam int unsigned MIN_PKT_BYTES = 64;
   localparam int unsigned MAX_PKT_BYTES = 9600;

   localparam int unsigned BEAT_DATA_W = 512;
   localparam int unsigned BEAT_KEEP_W = BEAT_DATA_W / 8;

   typedef struct packed {
      logic [BEAT_DATA_W-1:0] data;
      logic [BEAT_KEEP_W-1:0] keep;
      logic                   last;
      logic                   user;
   } beat_t;

   typedef enum logic [0:0] {
      S_HDR,
      S_BODY
   } rx_state_e;

endpackage

// File: rtl/udp_beat_pattern_check.sv
// Combinational check of one test-packet beat: payload pattern under tkeep,
// tkeep shape and number of valid bytes.
module udp_beat_pattern_check
   import udp_cmac_rx_pkt_checker_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned KEEP_WIDTH = 64,
   parameter int unsigned POP_W      = $clog2(KEEP_WIDTH + 1)
) (
   input  logic [15:0]           beat_idx_i,
   input  logic [7:0]            seq_lsb_i,
   input  logic                  last_i,
   input  logic [KEEP_WIDTH-1:0] keep_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  payload_err_o,
   output logic                  keep_err_o,
   output logic [POP_W-1:0]      popcount_o
);

   logic       is_hdr;
   logic [7:0] beat_base;

   assign is_hdr = (beat_idx_i == '0);
   // Pattern is mod 256, so only the low bits of the byte offset matter.
   assign beat_base = beat_idx_i[7:0] * 8'(KEEP_WIDTH);

   always_comb begin
      payload_err_o = 1'b0;
      popcount_o    = '0;
      for (int j = 0; j < KEEP_WIDTH; j++) begin
         if (keep_i[j]) begin
            popcount_o = popcount_o + POP_W'(1);
            if (!(is_hdr && (j < HDR_BYTES)) &&
                (data_i[8*j +: 8] != (seq_lsb_i + beat_base + 8'(j)))) begin
               payload_err_o = 1'b1;
            end
         end
      end
   end

   always_comb begin
      if (last_i) begin
         keep_err_o = (keep_i == '0) || ((keep_i & (keep_i + KEEP_WIDTH'(1))) != '0);
      end else begin
         keep_err_o = (keep_i != '1);
      end
   end

endmodule

// File: rtl/udp_cmac_rx_pkt_checker.sv
// Receive-side checker for the CMAC loopback performance test: validates each
// packet and exports good/errored packet, beat and cycle counters.
module udp_cmac_rx_pkt_checker
   import udp_cmac_rx_pkt_checker_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned KEEP_WIDTH = 64,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   input  logic                  cfg_enable,
   input  logic [31:0]           cfg_pkt_size,
   output logic [CNT_WIDTH-1:0]  recv_pkt_num,
   output logic [CNT_WIDTH-1:0]  err_pkt_num,
   output logic [CNT_WIDTH-1:0]  beat_count,
   output logic [CNT_WIDTH-1:0]  cycle_count,
   output logic                  cycle_count_full,
   output logic                  is_recv_first_pkt,
   output logic [4:0]            last_err_code
);

   localparam int unsigned POP_W = $clog2(KEEP_WIDTH + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   rx_state_e            state_q, state_d;
   logic [31:0]          seq_q, seq_d;
   logic [31:0]          len_q, len_d;
   logic [31:0]          acc_q, acc_d;
   logic [ERR_W-1:0]     flags_q, flags_d;
   logic [15:0]          beat_idx_q, beat_idx_d;
   logic [31:0]          exp_seq_q, exp_seq_d;
   logic                 resync_q, resync_d;
   logic                 tready_q;
   logic [CNT_WIDTH-1:0] recv_q, recv_d;
   logic [CNT_WIDTH-1:0] err_q, err_d;
   logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
   logic                 full_q, full_d;
   logic                 first_q, first_d;
   logic [ERR_W-1:0]     code_q, code_d;

   logic             hs, in_hdr, finish, en_rise, en_fall;
   logic [31:0]      cur_seq, cur_len, acc_new;
   logic [15:0]      chk_idx;
   logic             pay_err, keep_err;
   logic [POP_W-1:0] pop;
   logic [ERR_W-1:0] beat_flags, flags_new, fin_flags;

   assign hs      = s_axis_tvalid & tready_q;
   assign in_hdr  = (state_q == S_HDR);
   assign finish  = hs & s_axis_tlast;
   // tready_q doubles as the delayed enable for edge detection.
   assign en_rise = cfg_enable & ~tready_q;
   assign en_fall = ~cfg_enable & tready_q;

   assign cur_seq = in_hdr ? s_axis_tdata[SEQ_LSB +: 32] : seq_q;
   assign cur_len = in_hdr ? s_axis_tdata[LEN_LSB +: 32] : len_q;
   assign chk_idx = in_hdr ? '0 : beat_idx_q;

   udp_beat_pattern_check #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH),
      .POP_W      (POP_W)
   ) u_beat_check (
      .beat_idx_i    (chk_idx),
      .seq_lsb_i     (cur_seq[7:0]),
      .last_i        (s_axis_tlast),
      .keep_i        (s_axis_tkeep),
      .data_i        (s_axis_tdata),
      .payload_err_o (pay_err),
      .keep_err_o    (keep_err),
      .popcount_o    (pop)
   );

   always_comb begin
      beat_flags              = '0;
      beat_flags[ERR_SEQ]     = in_hdr & ~resync_q & (cur_seq != exp_seq_q);
      beat_flags[ERR_PAYLOAD] = pay_err;
      beat_flags[ERR_KEEP]    = keep_err;
      beat_flags[ERR_USER]    = s_axis_tuser;
      acc_new   = (in_hdr ? 32'd0 : acc_q) + 32'(pop);
      flags_new = (in_hdr ? '0 : flags_q) | beat_flags;
      fin_flags = flags_new;
      fin_flags[ERR_LEN] = (acc_new != cur_len) || (cur_len != cfg_pkt_size);
   end

   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q;
      len_d      = len_q;
      acc_d      = acc_q;
      flags_d    = flags_q;
      beat_idx_d = beat_idx_q;
      exp_seq_d  = exp_seq_q;
      resync_d   = resync_q;
      recv_d     = recv_q;
      err_d      = err_q;
      beat_cnt_d = beat_cnt_q;
      cyc_d      = cyc_q;
      full_d     = full_q;
      first_d    = first_q;
      code_d     = code_q;

      if (hs) begin
         seq_d      = cur_seq;
         len_d      = cur_len;
         acc_d      = acc_new;
         flags_d    = flags_new;
         beat_idx_d = in_hdr ? 16'd1 : ((beat_idx_q != '1) ? beat_idx_q + 16'd1 : beat_idx_q);
         state_d    = s_axis_tlast ? S_HDR : S_BODY;
         first_d    = 1'b1;
         if (!full_q && (beat_cnt_q != CNT_MAX)) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
      end

      if (finish) begin
         if (fin_flags == '0) begin
            if (recv_q != CNT_MAX) recv_d = recv_q + 1'b1;
         end else begin
            if (err_q != CNT_MAX) err_d = err_q + 1'b1;
            code_d = fin_flags;
         end
         exp_seq_d = cur_seq + 32'd1;
         resync_d  = 1'b0;
      end

      if (cfg_enable && first_q && !full_q) begin
         cyc_d = cyc_q + 1'b1;
         if (cyc_d == CNT_MAX) full_d = 1'b1;
      end

      // A non-last beat accepted on the disabling edge is dropped with the rest.
      if (en_fall) state_d = S_HDR;

      if (en_rise) begin
         state_d    = S_HDR;
         flags_d    = '0;
         resync_d   = 1'b1;
         recv_d     = '0;
         err_d      = '0;
         beat_cnt_d = '0;
         cyc_d      = '0;
         full_d     = 1'b0;
         first_d    = 1'b0;
         code_d     = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_HDR;
         seq_q      <= '0;
         len_q      <= '0;
         acc_q      <= '0;
         flags_q    <= '0;
         beat_idx_q <= '0;
         exp_seq_q  <= '0;
         resync_q   <= 1'b1;
         tready_q   <= 1'b0;
         recv_q     <= '0;
         err_q      <= '0;
         beat_cnt_q <= '0;
         cyc_q      <= '0;
         full_q     <= 1'b0;
         first_q    <= 1'b0;
         code_q     <= '0;
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         len_q      <= len_d;
         acc_q      <= acc_d;
         flags_q    <= flags_d;
         beat_idx_q <= beat_idx_d;
         exp_seq_q  <= exp_seq_d;
         resync_q   <= resync_d;
         tready_q   <= cfg_enable;
         recv_q     <= recv_d;
         err_q      <= err_d;
         beat_cnt_q <= beat_cnt_d;
         cyc_q      <= cyc_d;
         full_q     <= full_d;
         first_q    <= first_d;
         code_q     <= code_d;
      end
   end

   assign s_axis_tready     = tready_q;
   assign recv_pkt_num      = recv_q;
   assign err_pkt_num       = err_q;
   assign beat_count        = beat_cnt_q;
   assign cycle_count       = cyc_q;
   assign cycle_count_full  = full_q;
   assign is_recv_first_pkt = first_q;
   assign last_err_code     = code_q;

endmodule
